// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler: picks the highest-priority (lowest ID) pending
// mailbox, hands it to the transmitter, tracks completion / arbitration
// losses per mailbox and enforces interframe spacing.
module can_tx_scheduler #(
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned IFS_BITS     = 3,
    parameter int unsigned MAX_RETRY    = 7
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic [3:0]  i_Req,
    input  logic [10:0] i_Id0,
    input  logic [10:0] i_Id1,
    input  logic [10:0] i_Id2,
    input  logic [10:0] i_Id3,
    input  logic        i_Tx_Done,
    input  logic        i_Tx_Arb_Lost,
    output logic        o_Tx_Start,
    output logic [1:0]  o_Tx_Sel,
    output logic [10:0] o_Tx_Id,
    output logic        o_Busy,
    output logic [3:0]  o_Done,
    output logic [3:0]  o_Err
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        START,
        BUSY,
        INTERFRAME
    } state_t;

    localparam int unsigned IFS_CYCLES = IFS_BITS * CLKS_PER_BIT;
    localparam logic [15:0] IFS_LAST   = (IFS_CYCLES == 0) ? 16'd0 : 16'(IFS_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [10:0] id_q, id_d;
    logic [15:0] ifs_cnt_q, ifs_cnt_d;
    logic [3:0]  served_q, served_d;
    logic [3:0]  done_q, done_d;
    logic [3:0]  err_q, err_d;
    logic [2:0]  retry_q [4];
    logic [2:0]  retry_d [4];

    logic [10:0] ids [4];
    logic [3:0]  eligible;
    logic        found;
    logic [1:0]  best_sel;
    logic [10:0] best_id;
    logic [3:0]  retry_inc;

    // Priority search: lowest ID among eligible mailboxes, ties to lowest index
    always_comb begin
        ids[0]   = i_Id0;
        ids[1]   = i_Id1;
        ids[2]   = i_Id2;
        ids[3]   = i_Id3;
        eligible = i_Req & ~served_q;
        found    = 1'b0;
        best_sel = '0;
        best_id  = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (eligible[k] && (!found || ids[k] < best_id)) begin
                found    = 1'b1;
                best_sel = 2'(k);
                best_id  = ids[k];
            end
        end
    end

    // Next-state, selection, retry and completion logic
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        id_d      = id_q;
        ifs_cnt_d = ifs_cnt_q;
        retry_d   = retry_q;
        done_d    = '0;
        err_d     = '0;
        served_d  = (served_q | done_q | err_q) & i_Req;
        retry_inc = {1'b0, retry_q[sel_q]} + 4'd1;

        case (state_q)
            IDLE: begin
                if (|eligible) state_d = SELECT;
            end
            SELECT: begin
                if (found) begin
                    sel_d   = best_sel;
                    id_d    = best_id;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                state_d = BUSY;
            end
            BUSY: begin
                if (i_Tx_Done) begin
                    done_d[sel_q]  = 1'b1;
                    retry_d[sel_q] = '0;
                    ifs_cnt_d      = '0;
                    state_d        = INTERFRAME;
                end else if (i_Tx_Arb_Lost) begin
                    if (32'(retry_inc) > MAX_RETRY) begin
                        err_d[sel_q]   = 1'b1;
                        retry_d[sel_q] = '0;
                    end else if (retry_inc[3]) begin
                        retry_d[sel_q] = '1;
                    end else begin
                        retry_d[sel_q] = retry_inc[2:0];
                    end
                    ifs_cnt_d = '0;
                    state_d   = INTERFRAME;
                end
            end
            INTERFRAME: begin
                if (ifs_cnt_q >= IFS_LAST) begin
                    state_d = IDLE;
                end else begin
                    ifs_cnt_d = ifs_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            id_q      <= '0;
            ifs_cnt_q <= '0;
            served_q  <= '0;
            done_q    <= '0;
            err_q     <= '0;
            retry_q   <= '{default: '0};
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            id_q      <= id_d;
            ifs_cnt_q <= ifs_cnt_d;
            served_q  <= served_d;
            done_q    <= done_d;
            err_q     <= err_d;
            retry_q   <= retry_d;
        end
    end

    assign o_Tx_Start = (state_q == START);
    assign o_Busy     = (state_q != IDLE);
    assign o_Tx_Sel   = sel_q;
    assign o_Tx_Id    = id_q;
    assign o_Done     = done_q;
    assign o_Err      = err_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Scoreboard bench for can_tx_scheduler: stimulus pushes expected output
// events (with cycle gaps), a negedge monitor pops and compares them.
module tb_can_tx_scheduler;

    localparam int K_START = 0;
    localparam int K_DONE  = 1;
    localparam int K_ERR   = 2;
    localparam int K_IDLE  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [10:0] id0 = '0, id1 = '0, id2 = '0, id3 = '0;
    logic        tx_done = 1'b0;
    logic        tx_lost = 1'b0;
    logic        tx_start;
    logic [1:0]  tx_sel;
    logic [10:0] tx_id;
    logic        busy;
    logic [3:0]  done;
    logic [3:0]  err;

    int cyc     = 0;
    int ref_cyc = 0;
    int n_cmp   = 0;
    int n_bad   = 0;

    typedef struct {
        int          kind;
        logic [15:0] val;
        int          gap;
    } exp_t;

    exp_t exp_q[$];

    can_tx_scheduler #(
        .CLKS_PER_BIT(10),
        .IFS_BITS(3),
        .MAX_RETRY(7)
    ) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .i_Req(req),
        .i_Id0(id0),
        .i_Id1(id1),
        .i_Id2(id2),
        .i_Id3(id3),
        .i_Tx_Done(tx_done),
        .i_Tx_Arb_Lost(tx_lost),
        .o_Tx_Start(tx_start),
        .o_Tx_Sel(tx_sel),
        .o_Tx_Id(tx_id),
        .o_Busy(busy),
        .o_Done(done),
        .o_Err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_START: return "start";
            K_DONE:  return "done";
            K_ERR:   return "err";
            default: return "idle";
        endcase
    endfunction

    task automatic expect_evt(input int kind, input logic [15:0] val, input int gap);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic check_evt(input int kind, input logic [15:0] val);
        exp_t e;
        int   gap;
        gap     = cyc - ref_cyc;
        ref_cyc = cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_%s: got val=%h gap=%0d, required no event", kname(kind), val, gap);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || (e.gap >= 0 && e.gap != gap)) begin
                n_bad++;
                $display("FAIL evt_%s: got %s val=%h gap=%0d, required %s val=%h gap=%0d",
                         kname(e.kind), kname(kind), val, gap, kname(e.kind), e.val, e.gap);
            end
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every visible output event is matched against the scoreboard
    initial begin : monitor
        logic prev_busy;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) check_evt(K_START, {3'b0, tx_sel, tx_id});
            if ((|done) === 1'b1)  check_evt(K_DONE, {12'b0, done});
            if ((|err) === 1'b1)   check_evt(K_ERR, {12'b0, err});
            if (prev_busy === 1'b1 && busy === 1'b0) check_evt(K_IDLE, 16'h0);
            prev_busy = busy;
        end
    end

    task automatic raise(input logic [3:0] mask);
        @(posedge clk);
        #1;
        req     = mask;
        ref_cyc = cyc;
    endtask

    task automatic wait_start();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL start_timeout: got no o_Tx_Start in 300 cycles, required a start");
        end
    endtask

    task automatic pulse(input logic d, input logic l);
        repeat (3) @(posedge clk);
        #1;
        tx_done = d;
        tx_lost = l;
        ref_cyc = cyc;
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        tx_lost = 1'b0;
    endtask

    task automatic drain_and_drop();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("queue_drained", 16'(exp_q.size()), 16'h0);
        @(posedge clk);
        #1;
        req = '0;
        repeat (3) @(posedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_start"}, {15'b0, tx_start}, 16'h0);
        chk({tag, "_sel"},   {14'b0, tx_sel},   16'h0);
        chk({tag, "_id"},    {5'b0, tx_id},     16'h0);
        chk({tag, "_busy"},  {15'b0, busy},     16'h0);
        chk({tag, "_done"},  {12'b0, done},     16'h0);
        chk({tag, "_err"},   {12'b0, err},      16'h0);
    endtask

    initial begin : stimulus
        logic [1:0]  order [4];
        logic [10:0] oid   [4];

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single request, in-flight ID stability, no resend while held
        id0 = 11'h123;
        raise(4'b0001);
        expect_evt(K_START, {5'b0, 11'h123}, 2);
        wait_start();
        @(posedge clk);
        #1;
        id0 = 11'h456;
        repeat (2) @(negedge clk);
        chk("inflight_id", {5'b0, tx_id}, 16'h0123);
        chk("inflight_sel", {14'b0, tx_sel}, 16'h0);
        expect_evt(K_DONE, 16'h0001, 1);
        expect_evt(K_IDLE, 16'h0, 30);
        pulse(1'b1, 1'b0);
        drain_and_drop();
        repeat (50) @(posedge clk);
        #1;
        req = '0;
        repeat (3) @(posedge clk);

        // Priority order 3,1,2,0 with fixed interframe spacing
        id0 = 11'h300; id1 = 11'h050; id2 = 11'h050; id3 = 11'h010;
        order[0] = 2'd3; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd0;
        oid[0] = 11'h010; oid[1] = 11'h050; oid[2] = 11'h050; oid[3] = 11'h300;
        raise(4'b1111);
        expect_evt(K_START, {3'b0, order[0], oid[0]}, 2);
        for (int j = 0; j < 4; j++) begin
            wait_start();
            expect_evt(K_DONE, 16'(4'b0001 << order[j]), 1);
            expect_evt(K_IDLE, 16'h0, 30);
            if (j < 3) expect_evt(K_START, {3'b0, order[j+1], oid[j+1]}, 2);
            pulse(1'b1, 1'b0);
        end
        drain_and_drop();

        // Retry exhaustion on mailbox 2
        id2 = 11'h0AB;
        raise(4'b0100);
        expect_evt(K_START, {3'b0, 2'd2, 11'h0AB}, 2);
        for (int i = 1; i <= 8; i++) begin
            wait_start();
            if (i < 8) begin
                expect_evt(K_IDLE, 16'h0, 31);
                expect_evt(K_START, {3'b0, 2'd2, 11'h0AB}, 2);
            end else begin
                expect_evt(K_ERR, 16'h0004, 1);
                expect_evt(K_IDLE, 16'h0, 30);
            end
            pulse(1'b0, 1'b1);
        end
        drain_and_drop();
        repeat (40) @(posedge clk);

        // Preemption by a lower ID raised during INTERFRAME
        id0 = 11'h200; id1 = 11'h001;
        raise(4'b0001);
        expect_evt(K_START, {3'b0, 2'd0, 11'h200}, 2);
        wait_start();
        expect_evt(K_IDLE, 16'h0, 31);
        pulse(1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        req = 4'b0011;
        expect_evt(K_START, {3'b0, 2'd1, 11'h001}, 2);
        wait_start();
        expect_evt(K_DONE, 16'h0002, 1);
        expect_evt(K_IDLE, 16'h0, 30);
        expect_evt(K_START, {3'b0, 2'd0, 11'h200}, 2);
        pulse(1'b1, 1'b0);
        wait_start();
        expect_evt(K_DONE, 16'h0001, 1);
        expect_evt(K_IDLE, 16'h0, 30);
        pulse(1'b1, 1'b0);
        drain_and_drop();

        // Done and arbitration loss together count as done
        id2 = 11'h7FF;
        raise(4'b0100);
        expect_evt(K_START, {3'b0, 2'd2, 11'h7FF}, 2);
        wait_start();
        expect_evt(K_DONE, 16'h0004, 1);
        expect_evt(K_IDLE, 16'h0, 30);
        pulse(1'b1, 1'b1);
        drain_and_drop();

        // Reset during BUSY abandons the frame, held request is re-served
        id1 = 11'h0F0;
        raise(4'b0010);
        expect_evt(K_START, {3'b0, 2'd1, 11'h0F0}, 2);
        wait_start();
        repeat (2) @(posedge clk);
        #1;
        expect_evt(K_IDLE, 16'h0, 1);
        rst     = 1'b1;
        ref_cyc = cyc;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("busy_reset");
        @(posedge clk);
        #1;
        rst     = 1'b0;
        ref_cyc = cyc;
        expect_evt(K_START, {3'b0, 2'd1, 11'h0F0}, 2);
        wait_start();
        expect_evt(K_DONE, 16'h0002, 1);
        expect_evt(K_IDLE, 16'h0, 30);
        pulse(1'b1, 1'b0);
        drain_and_drop();

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
